// File: rtl/param_event_counter.sv
// Weighted event accumulator: sums in_weight over a valid/ready stream and emits one
// held report record when the sum reaches THRESHOLD. Optional out_ovf: PARAM_EVENT_COUNTER_OVF_EN.
module param_event_counter #(
  parameter bit AUTO_RESTART = 1'b1,
  parameter int THRESHOLD    = 18,
  parameter int ACC_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [7:0]       out_events,
`ifdef PARAM_EVENT_COUNTER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {ACCUM, REPORT, HALT} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] THRESH  = ACC_W'(THRESHOLD);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       events_q, events_d;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_sat;
  logic [7:0]       events_inc;
  logic             ev_full;
  logic             accept;
  logic             trigger;
  logic             handshake;

  // Sum is one bit wider than the accumulator so the carry flags saturation.
  assign sum        = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_weight};
  assign acc_sat    = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
  assign ev_full    = (events_q == 8'hFF);
  assign events_inc = ev_full ? 8'hFF : events_q + 8'd1;

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign accept    = in_valid && (state_q == ACCUM);
  assign trigger   = accept && (acc_sat >= THRESH);
  assign handshake = out_valid && out_ready;
  assign busy      = (state_q != ACCUM) || (acc_q != '0);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    events_d = events_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d    = acc_sat;
          events_d = events_inc;
          if (acc_sat >= THRESH) state_d = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          acc_d    = '0;
          events_d = '0;
          state_d  = AUTO_RESTART ? ACCUM : HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      events_q   <= '0;
      out_valid  <= 1'b0;
      out_total  <= '0;
      out_events <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      events_q  <= events_d;
      out_valid <= (state_d == REPORT);
      if (trigger) begin
        out_total  <= acc_sat;
        out_events <= events_inc;
      end
    end
  end

`ifdef PARAM_EVENT_COUNTER_OVF_EN
  logic sat_hit;
  assign sat_hit = accept && (sum[ACC_W] || ev_full);

  // Sticky until the record carrying it is handed off.
  always_ff @(posedge clk) begin
    if (rst)            out_ovf <= 1'b0;
    else if (handshake) out_ovf <= 1'b0;
    else if (sat_hit)   out_ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_param_event_counter.sv
// Self-checking bench: four parameterisations share one stimulus stream and are compared
// every cycle against an arithmetic reference model, plus directed scenario checks.
module tb_param_event_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_weight;
  logic       out_ready;

  logic        rdy [4];
  logic        vld [4];
  logic        bsy [4];
  logic        ovf [4];
  logic [7:0]  evs [4];
  logic [31:0] tot [4];
  logic [15:0] tot0, tot1, tot3;
  logic [8:0]  tot2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: restart, thr 18   1: halt, thr 18   2: 9-bit acc, thr 511   3: thr 0
  param_event_counter #(.AUTO_RESTART(1'b1), .THRESHOLD(18), .ACC_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_weight(in_weight),
    .out_valid(vld[0]), .out_ready(out_ready), .out_total(tot0), .out_events(evs[0]),
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    .out_ovf(ovf[0]),
`endif
    .busy(bsy[0]));
  param_event_counter #(.AUTO_RESTART(1'b0), .THRESHOLD(18), .ACC_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_weight(in_weight),
    .out_valid(vld[1]), .out_ready(out_ready), .out_total(tot1), .out_events(evs[1]),
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    .out_ovf(ovf[1]),
`endif
    .busy(bsy[1]));
  param_event_counter #(.AUTO_RESTART(1'b1), .THRESHOLD(511), .ACC_W(9)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_weight(in_weight),
    .out_valid(vld[2]), .out_ready(out_ready), .out_total(tot2), .out_events(evs[2]),
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    .out_ovf(ovf[2]),
`endif
    .busy(bsy[2]));
  param_event_counter #(.AUTO_RESTART(1'b1), .THRESHOLD(0), .ACC_W(16)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_weight(in_weight),
    .out_valid(vld[3]), .out_ready(out_ready), .out_total(tot3), .out_events(evs[3]),
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    .out_ovf(ovf[3]),
`endif
    .busy(bsy[3]));

`ifndef PARAM_EVENT_COUNTER_OVF_EN
  assign ovf[0] = 1'b0;
  assign ovf[1] = 1'b0;
  assign ovf[2] = 1'b0;
  assign ovf[3] = 1'b0;
`endif

  assign tot[0] = 32'(tot0);
  assign tot[1] = 32'(tot1);
  assign tot[2] = 32'(tot2);
  assign tot[3] = 32'(tot3);

  // Reference model: mode 0 = accumulating, 1 = report pending, 2 = halted.
  int p_thr  [4] = '{18, 18, 511, 0};
  int p_max  [4] = '{65535, 65535, 511, 65535};
  bit p_auto [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int m_mode [4];
  int m_acc  [4];
  int m_ev   [4];
  int m_tot  [4];
  int m_oev  [4];
  bit m_ovf  [4];
  bit m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d_in_ready", i), 32'(rdy[i]), 32'(m_mode[i] == 0 && !rst));
      check($sformatf("u%0d_out_valid", i), 32'(vld[i]), 32'(m_mode[i] == 1));
      check($sformatf("u%0d_out_total", i), tot[i], m_tot[i]);
      check($sformatf("u%0d_out_events", i), 32'(evs[i]), m_oev[i]);
      check($sformatf("u%0d_busy", i), 32'(bsy[i]), 32'(m_mode[i] != 0 || m_acc[i] != 0));
`ifdef PARAM_EVENT_COUNTER_OVF_EN
      check($sformatf("u%0d_out_ovf", i), 32'(ovf[i]), 32'(m_ovf[i]));
`endif
    end
  endtask

  task automatic update_model();
    int s;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_acc[i] = 0; m_ev[i] = 0;
        m_tot[i]  = 0; m_oev[i] = 0; m_ovf[i] = 1'b0;
      end else if (m_mode[i] == 0) begin
        if (in_valid) begin
          s = m_acc[i] + int'(in_weight);
          if (s > p_max[i]) begin
            s = p_max[i];
            m_ovf[i] = 1'b1;
          end
          if (m_ev[i] == 255) m_ovf[i] = 1'b1;
          else m_ev[i]++;
          m_acc[i] = s;
          if (m_acc[i] >= p_thr[i]) begin
            m_mode[i] = 1;
            m_tot[i]  = m_acc[i];
            m_oev[i]  = m_ev[i];
          end
        end
      end else if (m_mode[i] == 1) begin
        if (out_ready) begin
          m_acc[i] = 0; m_ev[i] = 0; m_ovf[i] = 1'b0;
          m_mode[i] = p_auto[i] ? 0 : 2;
        end
      end
    end
  endtask

  // One clock: compare current outputs on the falling edge, advance the model, then
  // return just after the rising edge so inputs can change away from it.
  task automatic step();
    @(negedge clk);
    if (m_known) check_model();
    update_model();
    m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] w, input logic rdy_out);
    in_valid  = 1'b1;
    in_weight = w;
    out_ready = rdy_out;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_weight = 8'd0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy", 32'(bsy[0]), 0);
    check("reset_out_valid", 32'(vld[0]), 0);

    // 5,6,7 back-to-back, consumer always ready
    beat(8'd5, 1'b1); beat(8'd6, 1'b1); beat(8'd7, 1'b1);
    check("tp1_valid", 32'(vld[0]), 1);
    check("tp1_total", tot[0], 18);
    check("tp1_events", 32'(evs[0]), 3);
    out_ready = 1'b1;
    step();
    check("tp1_cleared", 32'(vld[0]), 0);
    check("tp1_ready", 32'(rdy[0]), 1);

    // Held report with a third beat waiting
    reset_pulse();
    beat(8'd10, 1'b0); beat(8'd20, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("tp2_total", tot[0], 30);
      check("tp2_events", 32'(evs[0]), 2);
      check("tp2_in_ready", 32'(rdy[0]), 0);
      beat(8'd3, 1'b0);
    end
    check("tp2_total_last", tot[0], 30);
    beat(8'd3, 1'b1);
    beat(8'd3, 1'b0);
    check("tp2_third_beat_acc", 32'(bsy[0]), 1);

    // Threshold 0 with a zero-weight beat
    reset_pulse();
    beat(8'd0, 1'b0);
    check("tp3_valid", 32'(vld[3]), 1);
    check("tp3_total", tot[3], 0);
    check("tp3_events", 32'(evs[3]), 1);

    // Halt after accepted report, leave only by reset
    reset_pulse();
    beat(8'd255, 1'b0);
    out_ready = 1'b1;
    step();
    check("tp4_halt_ready", 32'(rdy[1]), 0);
    check("tp4_halt_valid", 32'(vld[1]), 0);
    check("tp4_halt_busy", 32'(bsy[1]), 1);
    check("tp4_halt_total", tot[1], 255);
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("tp4_post_ready", 32'(rdy[1]), 1);
    check("tp4_post_busy", 32'(bsy[1]), 0);

    // 9-bit saturation
    reset_pulse();
    beat(8'd255, 1'b0); beat(8'd255, 1'b0); beat(8'd255, 1'b0);
    check("tp5_total", tot[2], 511);
    check("tp5_events", 32'(evs[2]), 3);
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    check("tp5_ovf", 32'(ovf[2]), 1);
`endif
    out_ready = 1'b1;
    step();
    check("tp5_cleared", 32'(vld[2]), 0);
`ifdef PARAM_EVENT_COUNTER_OVF_EN
    check("tp5_ovf_cleared", 32'(ovf[2]), 0);
`endif

    // Reset while a report is pending
    reset_pulse();
    beat(8'd18, 1'b0);
    check("tp6_pending", 32'(vld[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("tp6_dropped", 32'(vld[0]), 0);
    check("tp6_acc_zero", 32'(bsy[0]), 0);

    // Zero-weight flood drives the event counter into saturation
    reset_pulse();
    for (int k = 0; k < 300; k++) beat(8'd0, 1'($urandom_range(0, 1)));
    beat(8'd20, 1'b0);
    check("sat_events", 32'(evs[0]), 255);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      in_weight = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(0, 40));
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
